// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle RV64I-subset CPU: opcodes, funct codes, ALU ops.
package cpu_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_DOUBLE  = 3'b011;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    typedef enum logic [1:0] {
        ADD,
        SUB,
        AND,
        OR
    } alu_op_e;

    // 64-bit wrap-around ALU; no flags beyond the caller's zero test.
    function automatic logic [XLEN-1:0] alu_compute(input alu_op_e op,
                                                    input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b);
        logic [XLEN-1:0] res;
        res = '0;
        case (op)
            ADD:     res = a + b;
            SUB:     res = a - b;
            AND:     res = a & b;
            OR:      res = a | b;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rv64_cpu_sequential_reg_file.sv
// 32 x 64-bit register file: two asynchronous reads, one synchronous write.
// x0 is hardwired to zero; all registers clear asynchronously on reset.
module rv64_cpu_sequential_reg_file
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] registers [32];

    // Register storage: async clear, write ignored when targeting x0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                registers[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            registers[waddr_i] <= wdata_i;
        end
    end

    // Combinational read ports; x0 forced to zero regardless of storage.
    always_comb begin
        rdata1_o = (raddr1_i == 5'd0) ? '0 : registers[raddr1_i];
        rdata2_o = (raddr2_i == 5'd0) ? '0 : registers[raddr2_i];
    end

endmodule

// File: rtl/rv64_cpu_sequential.sv
// Single-cycle RV64I-subset CPU (add, sub, and, or, addi, ld, sd, beq) with internal
// instruction memory, data memory and register file. Memories are loaded/inspected by
// hierarchy only (imem.memory, dmem.memory, reg_file.registers).
// Optional macro CPU_HALT_EN: an all-zero instruction freezes the pc until reset;
// without it the all-zero word is a plain NOP and the pc keeps advancing.
module rv64_cpu_sequential
    import cpu_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 256
) (
    input logic clk,
    input logic reset
);

    localparam int unsigned IAW = $clog2(IMEM_DEPTH);
    localparam int unsigned DAW = $clog2(DMEM_DEPTH);

    logic [XLEN-1:0] pc_current;
    logic [XLEN-1:0] pc_next;
    logic [31:0]     instruction;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;

    logic            branch;
    logic            mem_read;
    logic            mem_to_reg;
    logic            mem_write;
    logic            alu_src;
    logic            reg_write;

    alu_op_e         alu_op;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] reg_read_data1;
    logic [XLEN-1:0] reg_read_data2;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;
    logic            zero;
    logic [XLEN-1:0] mem_read_data;
    logic [XLEN-1:0] reg_write_data;
    logic            halt;
    logic            imem_hit;
    logic            dmem_hit;

    // Instruction memory; contents come from outside via hierarchy.
    if (1) begin : imem
        logic [31:0] memory [IMEM_DEPTH] = '{default: '0};
    end

    // Data memory, zeroed at time 0 and never reset.
    if (1) begin : dmem
        logic [XLEN-1:0] memory [DMEM_DEPTH] = '{default: '0};
    end

    assign imem_hit    = pc_current[XLEN-1:2] < (XLEN-2)'(IMEM_DEPTH);
    assign instruction = imem_hit ? imem.memory[pc_current[IAW+1:2]] : 32'h0;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    // Decoder: control lines, ALU op and immediate per opcode; unknown opcodes are NOPs.
    always_comb begin
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        alu_op     = ADD;
        imm        = '0;
        case (opcode)
            OP_R: begin
                reg_write = 1'b1;
                case (funct3)
                    F3_ADD_SUB: alu_op = funct7[5] ? SUB : ADD;
                    F3_AND:     alu_op = AND;
                    F3_OR:      alu_op = OR;
                    default:    alu_op = ADD;
                endcase
            end
            OP_IMM: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
                imm       = {{52{instruction[31]}}, instruction[31:20]};
            end
            OP_LOAD: begin
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                alu_src    = 1'b1;
                reg_write  = 1'b1;
                imm        = {{52{instruction[31]}}, instruction[31:20]};
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm       = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
            end
            OP_BRANCH: begin
                branch = 1'b1;
                alu_op = SUB;
                imm    = {{51{instruction[31]}}, instruction[31], instruction[7],
                          instruction[30:25], instruction[11:8], 1'b0};
            end
            default: ;
        endcase
    end

    rv64_cpu_sequential_reg_file reg_file (
        .clk      (clk),
        .reset    (reset),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (reg_read_data1),
        .rdata2_o (reg_read_data2),
        .we_i     (reg_write),
        .waddr_i  (rd),
        .wdata_i  (reg_write_data)
    );

    assign alu_b      = alu_src ? imm : reg_read_data2;
    assign alu_result = alu_compute(alu_op, reg_read_data1, alu_b);
    assign zero       = (alu_result == '0);

    // Data memory index drops the byte offset; out-of-range accesses read 0 / drop writes.
    assign dmem_hit      = alu_result[XLEN-1:3] < (XLEN-3)'(DMEM_DEPTH);
    assign mem_read_data = dmem_hit ? dmem.memory[alu_result[DAW+2:3]] : '0;

    // Data memory write port.
    always_ff @(posedge clk) begin
        if (mem_write && dmem_hit) begin
            dmem.memory[alu_result[DAW+2:3]] <= reg_read_data2;
        end
    end

    assign reg_write_data = mem_to_reg ? mem_read_data : alu_result;

`ifdef CPU_HALT_EN
    // All-zero word already decodes to no writes; here it also parks the pc.
    assign halt = (instruction == 32'h0);
`else
    assign halt = 1'b0;
`endif

    // Next pc: hold on halt, branch target when beq compares equal, else fall through.
    always_comb begin
        pc_next = pc_current + 64'd4;
        if (halt) begin
            pc_next = pc_current;
        end else if (branch && zero) begin
            pc_next = pc_current + imm;
        end
    end

    // Program counter with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_current <= '0;
        end else begin
            pc_current <= pc_next;
        end
    end

endmodule

// File: tb/tb_rv64_cpu_sequential.sv
// Directed bench for rv64_cpu_sequential: loads short programs through hierarchy and
// checks architectural state against hand-computed values.
module tb_rv64_cpu_sequential;

    logic clk;
    logic reset;

    int unsigned n_tests;
    int unsigned n_fail;

    rv64_cpu_sequential dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {im, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {im[11:5], rs2, rs1, 3'b011, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {im[12], im[10:5], rs2, rs1, 3'b000, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] im);
        return enc_i(im, rs1, 3'b000, rd, 7'b0010011);
    endfunction

    // Hold reset, load up to five words (rest zero), release reset on a falling edge.
    task automatic run_prog(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                            input logic [31:0] w3, input logic [31:0] w4);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 256; i++) dut.imem.memory[i] = 32'h0;
        dut.imem.memory[0] = w0;
        dut.imem.memory[1] = w1;
        dut.imem.memory[2] = w2;
        dut.imem.memory[3] = w3;
        dut.imem.memory[4] = w4;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        #1;
        check("reset_pc", dut.pc_current, 64'd0);
        check("reset_x1", dut.reg_file.registers[1], 64'd0);

        // 1: taken beq over three addi words to a zero word
        run_prog(32'h00000863, 32'h00400293, 32'h00400313, 32'h00400393, 32'h0);
        check("t1_pc0", dut.pc_current, 64'd0);
        step(1);
        check("t1_pc16", dut.pc_current, 64'd16);
        check("t1_inst0", {32'h0, dut.instruction}, 64'd0);
        check("t1_x5", dut.reg_file.registers[5], 64'd0);
        check("t1_x6", dut.reg_file.registers[6], 64'd0);
        check("t1_x7", dut.reg_file.registers[7], 64'd0);
        step(1);
`ifdef CPU_HALT_EN
        check("t1_halt_pc", dut.pc_current, 64'd16);
`else
        check("t1_nop_pc", dut.pc_current, 64'd20);
`endif

        // 2: add/sub with a negative immediate
        run_prog(addi(5'd1, 5'd0, 12'd10), addi(5'd2, 5'd0, 12'hFFD),
                 enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3),
                 enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd4), 32'h0);
        step(4);
        check("t2_x2", dut.reg_file.registers[2], 64'hFFFF_FFFF_FFFF_FFFD);
        check("t2_add", dut.reg_file.registers[3], 64'd7);
        check("t2_sub", dut.reg_file.registers[4], 64'd13);

        // 3: and/or
        run_prog(addi(5'd1, 5'd0, 12'h0F0), addi(5'd2, 5'd0, 12'h03C),
                 enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd3),
                 enc_r(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd4), 32'h0);
        step(4);
        check("t3_and", dut.reg_file.registers[3], 64'h30);
        check("t3_or", dut.reg_file.registers[4], 64'hFC);

        // 4: store then load through dmem word 1
        run_prog(addi(5'd1, 5'd0, 12'd42), enc_s(12'd8, 5'd1, 5'd0),
                 enc_i(12'd8, 5'd0, 3'b011, 5'd2, 7'b0000011), 32'h0, 32'h0);
        step(1);
        check("t4_sd_we", {63'd0, dut.mem_write}, 64'd1);
        step(1);
        check("t4_ld_pc", dut.pc_current, 64'd8);
        check("t4_mem_read", {63'd0, dut.mem_read}, 64'd1);
        check("t4_dmem1", dut.dmem.memory[1], 64'd42);
        check("t4_rdata", dut.mem_read_data, 64'd42);
        step(1);
        check("t4_x2", dut.reg_file.registers[2], 64'd42);

        // 5: write to x0 ignored, beq not taken
        run_prog(addi(5'd1, 5'd0, 12'd1), addi(5'd0, 5'd0, 12'd5),
                 enc_b(13'd8, 5'd2, 5'd1), 32'h0, 32'h0);
        step(2);
        check("t5_x0", dut.reg_file.registers[0], 64'd0);
        check("t5_pc8", dut.pc_current, 64'd8);
        check("t5_branch", {63'd0, dut.branch}, 64'd1);
        step(1);
        check("t5_not_taken", dut.pc_current, 64'd12);

        // 6: asynchronous reset mid-run
        run_prog(addi(5'd1, 5'd0, 12'd10), addi(5'd2, 5'd0, 12'd3), 32'h0, 32'h0, 32'h0);
        step(1);
        check("t6_x1", dut.reg_file.registers[1], 64'd10);
        check("t6_pc4", dut.pc_current, 64'd4);
        #2 reset = 1'b1;
        #1;
        check("t6_async_pc", dut.pc_current, 64'd0);
        check("t6_async_x1", dut.reg_file.registers[1], 64'd0);
        check("t6_dmem_kept", dut.dmem.memory[1], 64'd42);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
